// File: rtl/timer_pkg.sv
// Shared definitions for the countdown-timer controller: state codes and widths.
package timer_pkg;

    localparam int STATE_W     = 3;
    localparam int FIELD_W_DEF = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/timer_set_fsm_key_repeat.sv
// Key rising-edge detector with optional hold/auto-repeat (TIMER_AUTOREPEAT_EN).
// pulse is the bare edge; step is the edge plus any repeat steps.
module key_repeat #(
    parameter int HOLD_CYC  = 8,
    parameter int RPT_CYC   = 4,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse,
    output logic step
);

    logic key_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_q <= 1'b0;
        else     key_q <= key;
    end

    assign pulse = key & ~key_q;

    if (REPEAT_EN && (RPT_CYC < 1 || RPT_CYC > HOLD_CYC)) begin : g_cfg_err
        $error("key_repeat: RPT_CYC must lie in 1..HOLD_CYC");
    end

`ifdef TIMER_AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_rpt
        localparam int CNT_W = $clog2(HOLD_CYC + 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rpt;

        // cnt_q holds cycles since the edge; after a repeat it is rewound so the next hits RPT_CYC later.
        always_comb begin
            // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
            cnt_d = '0;
            rpt   = 1'b0;
            if (pulse) begin
                cnt_d = CNT_W'(1);
            end else if (key) begin
                if (cnt_q == CNT_W'(HOLD_CYC)) begin
                    rpt   = 1'b1;
                    cnt_d = CNT_W'(HOLD_CYC - RPT_CYC + 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign step = pulse | rpt;
    end else begin : g_norpt
        assign step = pulse;
    end
`else
    assign step = pulse;
`endif

endmodule

// File: rtl/timer_set_fsm.sv
// Countdown-timer controller: field editing, 1 Hz countdown, alarm at zero.
// Define TIMER_AUTOREPEAT_EN to enable hold-to-repeat on the inc/dec keys in EDIT.
module timer_set_fsm
    import timer_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter int LOW_MAX    = 59,
    parameter int TOP_MAX    = 23,
    parameter int HOLD_CYC   = 8,
    parameter int RPT_CYC    = 4,
    localparam int CUR_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
    localparam int VAL_W     = NUM_FIELDS * FIELD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_set,
    input  logic               key_start,
    input  logic               key_inc,
    input  logic               key_dec,
    input  logic               tick,
    output logic [VAL_W-1:0]   value,
    output logic [CUR_W-1:0]   cursor,
    output logic [STATE_W-1:0] state,
    output logic               blink,
    output logic               alarm,
    output logic               done_pulse
);

    state_e             state_q, state_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic               blink_q, blink_d;
    logic               alarm_q, alarm_d;
    logic               done_pulse_q, done_pulse_d;

    logic set_p, start_p, inc_p, dec_p, inc_s, dec_s;
    logic unused_set_step, unused_start_step;

    key_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .REPEAT_EN(1'b0)) u_key_set (
        .clk(clk), .rst(rst), .key(key_set), .pulse(set_p), .step(unused_set_step));
    key_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .REPEAT_EN(1'b0)) u_key_start (
        .clk(clk), .rst(rst), .key(key_start), .pulse(start_p), .step(unused_start_step));
    key_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .REPEAT_EN(1'b1)) u_key_inc (
        .clk(clk), .rst(rst), .key(key_inc), .pulse(inc_p), .step(inc_s));
    key_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .REPEAT_EN(1'b1)) u_key_dec (
        .clk(clk), .rst(rst), .key(key_dec), .pulse(dec_p), .step(dec_s));

    function automatic logic [FIELD_W-1:0] field_max(input int idx);
        return (idx == NUM_FIELDS - 1) ? FIELD_W'(TOP_MAX) : FIELD_W'(LOW_MAX);
    endfunction

    // Subtract one second: a zero field reloads its max and borrows from the field above.
    function automatic logic [VAL_W-1:0] countdown(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0]   r;
        logic [FIELD_W-1:0] f;
        logic               borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            f = v[i*FIELD_W +: FIELD_W];
            if (borrow) begin
                if (f == '0) begin
                    r[i*FIELD_W +: FIELD_W] = field_max(i);
                end else begin
                    r[i*FIELD_W +: FIELD_W] = f - FIELD_W'(1);
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [VAL_W-1:0]   dec_val;
    logic               value_nz;
    int                 cur_idx;
    logic [FIELD_W-1:0] cur_field, cur_max;

    assign dec_val  = countdown(value_q);
    assign value_nz = |value_q;

    always_comb begin
        cur_idx   = int'(cursor_q);
        cur_field = value_q[cur_idx*FIELD_W +: FIELD_W];
        cur_max   = field_max(cur_idx);
        state_d   = state_q;
        value_d   = value_q;
        cursor_d  = cursor_q;

        unique case (state_q)
            ST_IDLE: begin
                if (set_p) begin
                    state_d  = ST_EDIT;
                    cursor_d = CUR_W'(NUM_FIELDS - 1);
                end else if (start_p && value_nz) begin
                    state_d = ST_RUN;
                end
            end
            ST_EDIT: begin
                if (set_p) begin
                    if (cursor_q == '0) state_d = ST_IDLE;
                    else                cursor_d = cursor_q - CUR_W'(1);
                end else if (start_p) begin
                    state_d = value_nz ? ST_RUN : ST_IDLE;
                end else if (inc_s) begin
                    value_d[cur_idx*FIELD_W +: FIELD_W] =
                        (cur_field == cur_max) ? '0 : cur_field + FIELD_W'(1);
                end else if (dec_s) begin
                    value_d[cur_idx*FIELD_W +: FIELD_W] =
                        (cur_field == '0) ? cur_max : cur_field - FIELD_W'(1);
                end
            end
            ST_RUN: begin
                // Reaching zero outranks a simultaneous pause request.
                if (tick) begin
                    value_d = dec_val;
                    if (dec_val == '0)  state_d = ST_DONE;
                    else if (start_p)   state_d = ST_PAUSE;
                end else if (start_p) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_p) begin
                    state_d = ST_RUN;
                end else if (set_p) begin
                    value_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (set_p | start_p | inc_p | dec_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        blink_d      = (state_d == ST_EDIT && state_q == ST_EDIT) ? (blink_q ^ tick) : 1'b0;
        alarm_d      = (state_d == ST_DONE);
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            value_q      <= '0;
            cursor_q     <= '0;
            blink_q      <= 1'b0;
            alarm_q      <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            cursor_q     <= cursor_d;
            blink_q      <= blink_d;
            alarm_q      <= alarm_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign value      = value_q;
    assign cursor     = cursor_q;
    assign state      = state_q;
    assign blink      = blink_q;
    assign alarm      = alarm_q;
    assign done_pulse = done_pulse_q;

endmodule

// File: doc/timer_set_fsm.md
# timer_set_fsm

Parametrised successor to the timer-set control unit: a self-contained countdown-timer controller with an internal state register. It owns an N-field time value (for example hh:mm:ss). It lets the user select and edit each field with set/inc/dec keys, counts down on a 1 Hz tick, and raises an alarm at zero. It sits between the synchronised key inputs and the display mux/alarm driver of the digital clock.

## Interface
- `NUM_FIELDS`, 3: number of time fields. Field 0 is least significant.
- `FIELD_W`, 6: bits per field, binary-coded.
- `LOW_MAX`, 59: maximum value of fields 0..NUM_FIELDS-2.
- `TOP_MAX`, 23: maximum value of field NUM_FIELDS-1.
- `HOLD_CYC`, 8: cycles a key must be held before auto-repeat starts.
- `RPT_CYC`, 4: cycles between auto-repeat steps.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_set` in 1: synchronised key level. Advances the field cursor or enters edit.
- `key_start` in 1: synchronised key level. Start/pause.
- `key_inc` in 1: synchronised key level. Increments the cursor field.
- `key_dec` in 1: synchronised key level. Decrements the cursor field.
- `tick` in 1: one-cycle pulse at the count rate (1 Hz).
- `value` out NUM_FIELDS*FIELD_W: current time. Field i occupies bits [i*FIELD_W +: FIELD_W].
- `cursor` out clog2(NUM_FIELDS): index of the field being edited.
- `state` out 3: state code.
- `blink` out 1: display blank-enable for the cursor field.
- `alarm` out 1: high while in DONE.
- `done_pulse` out 1: one cycle high on entry to DONE.

## Operation
- Key actions fire on rising edges only. The edge is the current level ANDed with the registered previous level inverted.
- States and codes:
  - IDLE = 0
  - EDIT = 1
  - RUN = 2
  - PAUSE = 3
  - DONE = 4
  - Codes 5–7 are illegal and recover to IDLE, with value unchanged.
- IDLE:
  - set → EDIT, cursor = NUM_FIELDS-1.
  - start with value ≠ 0 → RUN.
  - start with value = 0 → stay in IDLE.
- EDIT:
  - Priority is set > start > inc > dec. Only one action is taken per cycle.
  - set: cursor decrements. At cursor = 0, set → IDLE instead.
  - start: → RUN if value ≠ 0, else → IDLE.
  - inc: field[cursor] +1. The field's max wraps to 0.
  - dec: field[cursor] −1. 0 wraps to the field's max.
  - Only the cursor field changes.
- RUN:
  - tick decrements value with borrow ripple. A field at 0 reloads its max and borrows from the next field up.
  - If the decrement result is all-zero → DONE.
  - start → PAUSE. set, inc and dec are ignored.
- PAUSE:
  - start → RUN.
  - set → value cleared to 0, → IDLE.
  - tick is ignored.
- DONE:
  - alarm = 1.
  - Any key edge → IDLE, alarm = 0.
  - value stays 0.
- blink:
  - Toggles on each tick while in EDIT.
  - Forced to 0 in every other state.
  - Reset to 0 on entry to EDIT.
- Arithmetic: increments and decrements never produce a value above the field's max. Loaded out-of-range values are impossible by construction.

## Timing
- Every output is registered and changes only on a rising `clk` edge.
- Reset values: value = 0, cursor = 0, state = IDLE, blink = 0, alarm = 0, done_pulse = 0, key history = 0.
- Latency: a key level first sampled high at edge n produces its action visible after edge n.
- A key high out of reset does not fire. The history is 0, so it fires on the first sampled edge after reset deasserts.
- Simultaneous tick and start in RUN:
  - The decrement is applied and the state moves to PAUSE.
  - If the decrement reaches zero, DONE wins and start is ignored.
- done_pulse is high exactly on the first cycle of DONE.
- Reset during any state, including mid-borrow, returns to the reset values on the next evaluation. No partial update survives.

## Configuration
- `TIMER_AUTOREPEAT_EN` defined:
  - In EDIT, holding inc or dec produces a further step after HOLD_CYC cycles from the initial edge.
  - After that, a step occurs every RPT_CYC cycles while the key is held.
  - Releasing the key clears the repeat counter.
  - Repeat steps obey the same priority and wrap rules as edges.
- Not defined: one step per press. The repeat counters are not synthesised.

## Structure
- Shared package/header `timer_pkg`:
  - state codes IDLE..DONE
  - state width (3)
  - default FIELD_W
- Sub-module `key_repeat`:
  - contains the edge detector and, when `TIMER_AUTOREPEAT_EN` is defined, the hold/repeat counter
  - outputs a one-cycle `step` pulse
  - instantiated once each for set, start, inc and dec
  - repeat is enabled only on inc and dec

## Test plan
- Reset: assert rst mid-RUN with value 00:00:30 → value = 0, state = 0, alarm = 0 immediately; no action on the first cycle after release.
- Edit wrap: IDLE, set → EDIT, cursor = 2. inc ×24 from 00 → field2 = 00. dec from 00 → 23. set ×3 → IDLE, cursor back to 0.
- Countdown: load 00:01:00, start, 1 tick → 00:00:59. After 59 more ticks → DONE, alarm = 1, done_pulse high for exactly one cycle.
- Zero start: value 0, start in IDLE → stays IDLE. With a nonzero value in EDIT, start → RUN.
- Collision: in RUN at 00:00:05, tick and start in the same cycle → 00:00:04, PAUSE. At 00:00:01, same stimulus → DONE.
- Auto-repeat: in EDIT with field 0 at 10, hold inc for HOLD_CYC + 3·RPT_CYC = 20 cycles → 14 with `TIMER_AUTOREPEAT_EN`, 11 without.
